// File: rtl/inv_job_sched.sv
// inv_job_sched: job queue and launch/timeout sequencer for the image-inversion engine.
// Buffers {src, dst, len} jobs, fires one engine start per job, waits for done
// with a watchdog, and pulses irq when the last queued job retires.

module inv_job_sched #(
    parameter int QDEPTH  = 4,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_W-1:0]        cmd_src,
    input  logic [ADDR_W-1:0]        cmd_dst,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     eng_start,
    output logic [ADDR_W-1:0]        eng_src,
    output logic [ADDR_W-1:0]        eng_dst,
    output logic [LEN_W-1:0]         eng_len,
    input  logic                     eng_done,
    output logic                     eng_abort,
    output logic                     busy,
    output logic [$clog2(QDEPTH):0]  q_level,
    output logic [15:0]              jobs_done,
    output logic                     err_timeout,
    input  logic                     err_clr,
    output logic                     irq
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RETIRE} state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0] q_src [QDEPTH];
    logic [ADDR_W-1:0] q_dst [QDEPTH];
    logic [LEN_W-1:0]  q_len [QDEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TMR_W-1:0] timer;
    logic             full;
    logic             push;
    logic             pop;
    logic             expire;
    logic             timeout_hit;
    logic [LEN_W-1:0] head_len;

    // The timer holds the WAIT cycles still allowed; the last allowed cycle is timer==1.
    assign full        = (count == CNT_W'(QDEPTH));
    assign push        = cmd_valid && !full;
    assign pop         = (state == IDLE) && run && (count != '0);
    assign head_len    = q_len[rd_ptr];
    assign expire      = (timer == TMR_W'(1));
    assign timeout_hit = (state == WAIT) && !eng_done && expire;

    // Queue storage; entries need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_src[wr_ptr] <= cmd_src;
            q_dst[wr_ptr] <= cmd_dst;
            q_len[wr_ptr] <= cmd_len;
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; zero-length jobs skip the engine and retire directly.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = (head_len != '0) ? LAUNCH : RETIRE;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (eng_done || expire) state_next = RETIRE;
            RETIRE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Job latches, watchdog, abort pulse, sticky error and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_src     <= '0;
            eng_dst     <= '0;
            eng_len     <= '0;
            timer       <= '0;
            eng_abort   <= 1'b0;
            err_timeout <= 1'b0;
            jobs_done   <= '0;
        end else begin
            if (pop) begin
                eng_src <= q_src[rd_ptr];
                eng_dst <= q_dst[rd_ptr];
                eng_len <= head_len;
            end
            if (state == LAUNCH)
                timer <= TMR_W'(TIMEOUT);
            else if (state == WAIT && !eng_done)
                timer <= timer - TMR_W'(1);
            eng_abort <= timeout_hit;
            if (timeout_hit)
                err_timeout <= 1'b1;
            else if (err_clr)
                err_timeout <= 1'b0;
            if (state == RETIRE)
                jobs_done <= jobs_done + 16'd1;
        end
    end

    // Moore outputs from state and queue occupancy; irq also looks at a landing push.
    always_comb begin
        cmd_ready = !full;
        eng_start = (state == LAUNCH);
        busy      = (state != IDLE) || (count != '0);
        q_level   = count;
        irq       = (state == RETIRE) && (count == '0) && !push;
    end

endmodule

// File: tb/tb_inv_job_sched.sv
// tb_inv_job_sched: directed plus randomized bench for inv_job_sched with a job scoreboard,
// an engine responder and a monitor that models abort/error behaviour.

module tb_inv_job_sched;

    localparam int QDEPTH  = 4;
    localparam int ADDR_W  = 32;
    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 40;
    localparam int LVL_W   = $clog2(QDEPTH) + 1;

    typedef struct {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
    } job_t;

    logic              clk;
    logic              rst;
    logic              run;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;
    logic              eng_start;
    logic [ADDR_W-1:0] eng_src;
    logic [ADDR_W-1:0] eng_dst;
    logic [LEN_W-1:0]  eng_len;
    logic              eng_done;
    logic              eng_abort;
    logic              busy;
    logic [LVL_W-1:0]  q_level;
    logic [15:0]       jobs_done;
    logic              err_timeout;
    logic              err_clr;
    logic              irq;

    job_t expQ[$];
    job_t mj;
    int   checks       = 0;
    int   errors       = 0;
    int   acceptedCnt  = 0;
    int   startCnt     = 0;
    int   irqCnt       = 0;
    int   cyc          = 0;
    int   pendAbortCyc = -1;
    int   doneDelay    = 0;
    bit   modelErr     = 1'b0;
    bit   clrPrev      = 1'b0;
    bit   expAbort;

    inv_job_sched #(
        .QDEPTH(QDEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .eng_start(eng_start), .eng_src(eng_src), .eng_dst(eng_dst), .eng_len(eng_len),
        .eng_done(eng_done), .eng_abort(eng_abort), .busy(busy),
        .q_level(q_level), .jobs_done(jobs_done),
        .err_timeout(err_timeout), .err_clr(err_clr), .irq(irq)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 500000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one job for a cycle; accepted jobs are queued in the scoreboard.
    task automatic applyStimulus(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                                 input logic [LEN_W-1:0] l, output bit acc);
        job_t j;
        cmd_valid = 1'b1;
        cmd_src   = s;
        cmd_dst   = d;
        cmd_len   = l;
        @(negedge clk);
        acc = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (acc) begin
            j.src = s;
            j.dst = d;
            j.len = l;
            expQ.push_back(j);
            acceptedCnt++;
        end
    endtask

    task automatic waitIdle(input int maxCyc, input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic waitStart(input int maxCyc, input string name);
        int n = 0;
        @(negedge clk);
        while (!eng_start && n < maxCyc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, eng_start, 1);
        @(posedge clk);
        #1;
    endtask

    // Engine model: answers each launch with a done pulse doneDelay cycles later (0 = never).
    initial begin
        int k;
        eng_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && eng_start && doneDelay != 0) begin
                k = doneDelay;
                repeat (k) @(posedge clk);
                #1 eng_done = 1'b1;
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    // Monitor: matches launches against the job queue and tracks abort/error expectations.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            expQ.delete();
            acceptedCnt  = 0;
            pendAbortCyc = -1;
            modelErr     = 1'b0;
            clrPrev      = 1'b0;
        end else begin
            if (eng_start) begin
                startCnt++;
                while (expQ.size() > 0 && expQ[0].len == '0) void'(expQ.pop_front());
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL launch: got eng_start with len 0x%0h, required no launch (queue empty)", eng_len);
                end else begin
                    mj = expQ.pop_front();
                    checkOutput("eng_src", eng_src, mj.src);
                    checkOutput("eng_dst", eng_dst, mj.dst);
                    checkOutput("eng_len", eng_len, 32'(mj.len));
                end
                pendAbortCyc = (doneDelay == 0 || doneDelay > TIMEOUT) ? cyc + TIMEOUT + 1 : -1;
            end
            expAbort = (cyc == pendAbortCyc);
            if (eng_abort || expAbort) checkOutput("eng_abort", eng_abort, 32'(expAbort));
            if (expAbort)     modelErr = 1'b1;
            else if (clrPrev) modelErr = 1'b0;
            checkOutput("err_timeout", err_timeout, 32'(modelErr));
            clrPrev = err_clr;
            if (irq) begin
                irqCnt++;
                checkOutput("irq_q_level", q_level, 0);
            end
        end
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        bit acc;
        int nAcc;
        int i0;
        int s0;
        int nz;
        logic [LEN_W-1:0] rl;

        rst = 1'b1; run = 1'b0; cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0;
        cmd_len = '0; err_clr = 1'b0;
        tick(3);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_q_level", q_level, 0);
        checkOutput("rst_jobs_done", jobs_done, 0);
        checkOutput("rst_eng_start", eng_start, 0);
        checkOutput("rst_eng_abort", eng_abort, 0);
        checkOutput("rst_irq", irq, 0);
        checkOutput("rst_eng_len", eng_len, 0);
        rst = 1'b0;
        tick(1);

        $display("[TB] scenario 1: single job latency");
        run = 1'b1; doneDelay = 20; i0 = irqCnt;
        applyStimulus(32'h0, 32'h0, 16'd785, acc);
        checkOutput("t1_accept", acc, 1);
        @(negedge clk);
        checkOutput("t1_start_early", eng_start, 0);
        @(negedge clk);
        checkOutput("t1_start", eng_start, 1);
        checkOutput("t1_len", eng_len, 785);
        @(posedge clk); #1;
        waitIdle(100, "t1_idle");
        checkOutput("t1_jobs_done", jobs_done, 1);
        checkOutput("t1_irq", irqCnt - i0, 1);

        $display("[TB] scenario 2: full queue and timeouts");
        run = 1'b0; doneDelay = 0; nAcc = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h100 * i, 32'h8000 + 32'h10 * i, 16'(i + 1), acc);
            nAcc += int'(acc);
            if (i == 4) checkOutput("t2_fifth_rejected", acc, 0);
        end
        checkOutput("t2_accepted", nAcc, 4);
        checkOutput("t2_q_full", q_level, 4);
        checkOutput("t2_ready_low", cmd_ready, 0);
        run = 1'b1; i0 = irqCnt;
        tick(1);
        checkOutput("t2_q_after_pop", q_level, 3);
        checkOutput("t2_ready_back", cmd_ready, 1);
        waitIdle(4 * (TIMEOUT + 8), "t2_idle");
        checkOutput("t2_jobs_done", jobs_done, 32'(acceptedCnt));
        checkOutput("t2_err", err_timeout, 1);
        checkOutput("t2_irq", irqCnt - i0, 1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        checkOutput("t2_err_clr", err_timeout, 0);

        $display("[TB] scenario 3: zero-length job");
        doneDelay = 5; i0 = irqCnt;
        applyStimulus(32'h40, 32'h80, 16'd0, acc);
        applyStimulus(32'h0, 32'h1000, 16'd4, acc);
        waitStart(10, "t3_start");
        checkOutput("t3_done_before", jobs_done, 32'(acceptedCnt - 1));
        checkOutput("t3_no_irq_yet", irqCnt - i0, 0);
        waitIdle(40, "t3_idle");
        checkOutput("t3_jobs_done", jobs_done, 32'(acceptedCnt));
        checkOutput("t3_irq", irqCnt - i0, 1);

        $display("[TB] scenario 4: done on expiry cycle");
        doneDelay = TIMEOUT;
        applyStimulus(32'h200, 32'h300, 16'd7, acc);
        waitIdle(TIMEOUT + 10, "t4_idle_a");
        checkOutput("t4_no_err", err_timeout, 0);
        checkOutput("t4_jobs_a", jobs_done, 32'(acceptedCnt));
        doneDelay = TIMEOUT + 1;
        applyStimulus(32'h204, 32'h304, 16'd8, acc);
        waitIdle(TIMEOUT + 10, "t4_idle_b");
        checkOutput("t4_late_err", err_timeout, 1);
        checkOutput("t4_jobs_b", jobs_done, 32'(acceptedCnt));
        err_clr = 1'b1; tick(1); err_clr = 1'b0;

        $display("[TB] scenario 5: run gating");
        run = 1'b0; doneDelay = 10; s0 = startCnt;
        applyStimulus(32'h10, 32'h20, 16'd3, acc);
        applyStimulus(32'h14, 32'h24, 16'd5, acc);
        tick(5);
        checkOutput("t5_no_start", startCnt - s0, 0);
        checkOutput("t5_q_level", q_level, 2);
        run = 1'b1;
        waitIdle(100, "t5_idle_a");
        checkOutput("t5_two_starts", startCnt - s0, 2);
        applyStimulus(32'h30, 32'h40, 16'd9, acc);
        applyStimulus(32'h34, 32'h44, 16'd9, acc);
        waitStart(10, "t5_start_c");
        run = 1'b0;
        tick(30);
        checkOutput("t5_q_hold", q_level, 1);
        checkOutput("t5_jobs_mid", jobs_done, 32'(acceptedCnt - 1));
        run = 1'b1;
        waitIdle(100, "t5_idle_b");
        checkOutput("t5_jobs_end", jobs_done, 32'(acceptedCnt));

        $display("[TB] scenario 6: reset during WAIT");
        doneDelay = 0;
        applyStimulus(32'h50, 32'h60, 16'd2, acc);
        applyStimulus(32'h54, 32'h64, 16'd2, acc);
        waitStart(10, "t6_start");
        tick(5);
        rst = 1'b1;
        tick(1);
        checkOutput("t6_q_level", q_level, 0);
        checkOutput("t6_jobs_done", jobs_done, 0);
        checkOutput("t6_cmd_ready", cmd_ready, 1);
        checkOutput("t6_no_abort", eng_abort, 0);
        checkOutput("t6_busy", busy, 0);
        rst = 1'b0;
        tick(1);

        $display("[TB] scenario 7: randomized traffic");
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 9) == 0) doneDelay = TIMEOUT + int'($urandom_range(0, 2));
            else                           doneDelay = int'($urandom_range(1, 12));
            run = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) begin
                err_clr = 1'b1; tick(1); err_clr = 1'b0;
            end
            rl = ($urandom_range(0, 4) == 0) ? '0 : LEN_W'($urandom_range(1, 500));
            applyStimulus($urandom, $urandom, rl, acc);
            tick(int'($urandom_range(0, 4)));
        end
        run = 1'b1;
        waitIdle(3000, "rand_idle");
        checkOutput("rand_jobs_done", jobs_done, 32'(acceptedCnt & 16'hFFFF));
        nz = 0;
        foreach (expQ[k]) if (expQ[k].len != '0) nz++;
        checkOutput("rand_unlaunched", nz, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
